// File: rtl/axi4_lite_slv_regs.sv
// AXI4-Lite slave register bank: P_NUM_REGS registers with byte strobes, read-only slots and SLVERR decode.
// Latency: write commits one edge after both AW and W are held; read data is valid the edge after the AR handshake.
// Backpressure: one AW and one W slot; no commit while B is pending; one read outstanding (arready = !rvalid).
// Ports: AXI4-Lite AW/W/B/AR/R channels; reg_q flat register contents; reg_d hardware values for
//        read-only registers; wr_pulse one-cycle strobe per successfully written register.
module axi4_lite_slv_regs #(
    parameter int                    P_DATA_WIDTH = 32,
    parameter int                    P_ADDR_WIDTH = 32,
    parameter int                    P_NUM_REGS   = 16,
    parameter logic [P_NUM_REGS-1:0] P_RO_MASK    = '0
) (
    input  logic                               clk,
    input  logic                               arst_n,
    input  logic                               awvalid,
    output logic                               awready,
    input  logic [P_ADDR_WIDTH-1:0]            awaddr,
    input  logic [2:0]                         awprot,
    input  logic                               wvalid,
    output logic                               wready,
    input  logic [P_DATA_WIDTH-1:0]            wdata,
    input  logic [P_DATA_WIDTH/8-1:0]          wstrb,
    output logic                               bvalid,
    input  logic                               bready,
    output logic [1:0]                         bresp,
    input  logic                               arvalid,
    output logic                               arready,
    input  logic [P_ADDR_WIDTH-1:0]            araddr,
    input  logic [2:0]                         arprot,
    output logic                               rvalid,
    input  logic                               rready,
    output logic [P_DATA_WIDTH-1:0]            rdata,
    output logic [1:0]                         rresp,
    output logic [P_NUM_REGS*P_DATA_WIDTH-1:0] reg_q,
    input  logic [P_NUM_REGS*P_DATA_WIDTH-1:0] reg_d,
    output logic [P_NUM_REGS-1:0]              wr_pulse
);

    localparam int         STRB_W      = P_DATA_WIDTH / 8;
    localparam int         ADDR_LSB    = $clog2(STRB_W);
    localparam int         REG_BITS    = P_NUM_REGS * P_DATA_WIDTH;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                    aw_held_q, aw_held_d;
    logic [P_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                    w_held_q,  w_held_d;
    logic [P_DATA_WIDTH-1:0] w_data_q,  w_data_d;
    logic [STRB_W-1:0]       w_strb_q,  w_strb_d;
    logic                    bvalid_q,  bvalid_d;
    logic [1:0]              bresp_q,   bresp_d;
    logic                    rvalid_q,  rvalid_d;
    logic [P_DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [1:0]              rresp_q,   rresp_d;
    logic [REG_BITS-1:0]     regs_q,    regs_d;
    logic [P_NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
    logic [P_ADDR_WIDTH-1:0] aw_idx, ar_idx;
    logic [P_NUM_REGS-1:0]   wr_sel, rd_sel, wr_ok_sel;
    logic [P_DATA_WIDTH-1:0] rd_mux;

    // Readies depend only on internal state and reset, never on an input valid.
    assign awready = arst_n & ~aw_held_q;
    assign wready  = arst_n & ~w_held_q;
    assign arready = arst_n & ~rvalid_q;

    assign aw_hs  = awvalid & awready;
    assign w_hs   = wvalid & wready;
    assign b_hs   = bvalid_q & bready;
    assign ar_hs  = arvalid & arready;
    assign r_hs   = rvalid_q & rready;
    assign commit = aw_held_q & w_held_q & ~bvalid_q;

    // Full-width index compare so out-of-range addresses never alias onto a register.
    assign aw_idx = aw_addr_q >> ADDR_LSB;
    assign ar_idx = araddr >> ADDR_LSB;

    always_comb begin
        wr_sel = '0;
        rd_sel = '0;
        rd_mux = '0;
        for (int i = 0; i < P_NUM_REGS; i++) begin
            wr_sel[i] = (aw_idx == P_ADDR_WIDTH'(i));
            rd_sel[i] = (ar_idx == P_ADDR_WIDTH'(i));
            if (rd_sel[i]) begin
                rd_mux = P_RO_MASK[i] ? reg_d[i*P_DATA_WIDTH +: P_DATA_WIDTH]
                                      : regs_q[i*P_DATA_WIDTH +: P_DATA_WIDTH];
            end
        end
    end

    // Zero when the address is out of range or targets a read-only register.
    assign wr_ok_sel = wr_sel & ~P_RO_MASK;

    always_comb begin
        aw_held_d  = aw_held_q;
        aw_addr_d  = aw_addr_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;

        // A slot handshake and a commit can never coincide: the handshake needs the slot empty.
        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = awaddr;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end

        if (commit) begin
            for (int i = 0; i < P_NUM_REGS; i++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wr_ok_sel[i] && w_strb_q[b]) begin
                        regs_d[i*P_DATA_WIDTH + b*8 +: 8] = w_data_q[b*8 +: 8];
                    end
                end
            end
            aw_held_d  = 1'b0;
            w_held_d   = 1'b0;
            bvalid_d   = 1'b1;
            bresp_d    = (|wr_ok_sel) ? RESP_OKAY : RESP_SLVERR;
            wr_pulse_d = wr_ok_sel;
        end else if (b_hs) begin
            bvalid_d = 1'b0;
        end

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
            rresp_d  = (|rd_sel) ? RESP_OKAY : RESP_SLVERR;
        end else if (r_hs) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            aw_held_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            regs_q     <= '0;
            wr_pulse_q <= '0;
        end else begin
            aw_held_q  <= aw_held_d;
            aw_addr_q  <= aw_addr_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign rresp    = rresp_q;
    assign reg_q    = regs_q;
    assign wr_pulse = wr_pulse_q;

    // Protection bits carry no meaning here; writable-register slices of reg_d are don't-care.
    logic unused_inputs;
    assign unused_inputs = ^{awprot, arprot, reg_d, aw_addr_q[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axi4_lite_slv_regs.sv
module tb_axi4_lite_slv_regs;

    localparam int             NR = 16;
    localparam logic [NR-1:0]  RO = 16'h0001;

    logic          clk;
    logic          arst_n;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [31:0]   awaddr, araddr, wdata, rdata;
    logic [2:0]    awprot, arprot;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic [511:0]  reg_q, reg_d;
    logic [15:0]   wr_pulse;

    axi4_lite_slv_regs #(
        .P_DATA_WIDTH(32), .P_ADDR_WIDTH(32), .P_NUM_REGS(NR), .P_RO_MASK(RO)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .reg_q(reg_q), .reg_d(reg_d), .wr_pulse(wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] model [NR];

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic [15:0] exp_pulse;
    } vec_t;
    vec_t vecs [11];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] reg_slice(input int i);
        return reg_q[i*32 +: 32];
    endfunction

    function automatic logic [511:0] model_flat();
        logic [511:0] f;
        for (int i = 0; i < NR; i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    // Reference: byte-merge into the addressed register unless out of range or read-only.
    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp, output logic [15:0] pulse);
        int idx;
        idx = int'(a / 4);
        pulse = '0;
        if (idx >= NR || RO[idx]) begin
            resp = 2'b10;
        end else begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
            resp = 2'b00;
            pulse[idx] = 1'b1;
        end
    endtask

    task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int idx;
        idx = int'(a / 4);
        if (idx >= NR) begin
            d = '0; resp = 2'b10;
        end else if (RO[idx]) begin
            d = reg_d[idx*32 +: 32]; resp = 2'b00;
        end else begin
            d = model[idx]; resp = 2'b00;
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [15:0] pulse, output int lat);
        logic awd, wd, awr, wr;
        int n;
        awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s; bready = 1'b0;
        awd = 1'b0; wd = 1'b0; n = 0;
        while (!(awd && wd) && n < 20) begin
            awr = awready; wr = wready;
            tick(); n++;
            if (awvalid && awr) begin awd = 1'b1; awvalid = 1'b0; end
            if (wvalid && wr)   begin wd  = 1'b1; wvalid  = 1'b0; end
        end
        check("aw_w_handshake", {awd, wd}, 2'b11);
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < 20) begin tick(); lat++; end
        check("bvalid_seen", bvalid, 1'b1);
        resp = bresp; pulse = wr_pulse;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic done, arr;
        int n;
        arvalid = 1'b1; araddr = a; rready = 1'b0;
        done = 1'b0; n = 0;
        while (!done && n < 20) begin
            arr = arready;
            tick(); n++;
            if (arr) begin done = 1'b1; arvalid = 1'b0; end
        end
        arvalid = 1'b0;
        check("ar_handshake", done, 1'b1);
        n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        check("rvalid_seen", rvalid, 1'b1);
        d = rdata; resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp, eresp;
        logic [15:0] pulse, epulse;
        logic [31:0] data, edata, a, d;
        logic [3:0]  s;
        int lat;

        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; awprot = 0; arprot = 0;
        reg_d = '0; reg_d[31:0] = 32'hCAFE0001;
        for (int i = 0; i < NR; i++) model[i] = '0;

        // Reset state
        arst_n = 1'b1;
        #1 arst_n = 1'b0;
        #10;
        check("rst_awready", awready, 1'b0);
        check("rst_wready", wready, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_outputs", {bresp, rresp, rdata, wr_pulse}, '0);
        check("rst_reg_q", reg_q, '0);
        #11 arst_n = 1'b1;
        #1;
        check("rel_readies", {awready, wready, arready}, 3'b111);
        tick();

        // Directed table
        vecs[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00, 16'h0002};
        vecs[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00, 16'h0};
        vecs[2]  = '{1'b1, 32'h04, 32'h11223344, 4'h5, 32'h0,        2'b00, 16'h0002};
        vecs[3]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDE22BE44, 2'b00, 16'h0};
        vecs[4]  = '{1'b1, 32'h40, 32'h12345678, 4'hF, 32'h0,        2'b10, 16'h0};
        vecs[5]  = '{1'b0, 32'h40, 32'h0,        4'h0, 32'h0,        2'b10, 16'h0};
        vecs[6]  = '{1'b1, 32'h00, 32'h12345678, 4'hF, 32'h0,        2'b10, 16'h0};
        vecs[7]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'hCAFE0001, 2'b00, 16'h0};
        vecs[8]  = '{1'b0, 32'h06, 32'h0,        4'h0, 32'hDE22BE44, 2'b00, 16'h0};
        vecs[9]  = '{1'b1, 32'h3C, 32'hFFFFFFFF, 4'h8, 32'h0,        2'b00, 16'h8000};
        vecs[10] = '{1'b0, 32'h3C, 32'h0,        4'h0, 32'hFF000000, 2'b00, 16'h0};
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].is_wr) begin
                model_write(vecs[i].addr, vecs[i].data, vecs[i].strb, eresp, epulse);
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, pulse, lat);
                check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
                check($sformatf("vec%0d_wr_pulse", i), pulse, vecs[i].exp_pulse);
                check($sformatf("vec%0d_latency", i), lat, 1);
                check($sformatf("vec%0d_pulse_end", i), wr_pulse, 16'h0);
                check($sformatf("vec%0d_reg_q", i), reg_q, model_flat());
            end else begin
                axi_read(vecs[i].addr, data, resp);
                check($sformatf("vec%0d_rdata", i), data, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
            end
        end

        // W three cycles ahead of AW, B held off, second write queued behind B
        bready = 1'b0;
        wvalid = 1'b1; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
        check("A_wready_idle", wready, 1'b1);
        tick();
        wvalid = 1'b0;
        check("A_w_slot_full", wready, 1'b0);
        tick(); tick();
        check("A_no_commit_before_aw", bvalid, 1'b0);
        awvalid = 1'b1; awaddr = 32'h0C;
        check("A_awready", awready, 1'b1);
        tick();
        awvalid = 1'b0;
        check("A_not_yet_committed", bvalid, 1'b0);
        tick();
        check("A_bvalid", bvalid, 1'b1);
        check("A_bresp", bresp, 2'b00);
        check("A_wr_pulse", wr_pulse, 16'h0008);
        check("A_reg3", reg_slice(3), 32'hA5A5A5A5);
        model[3] = 32'hA5A5A5A5;
        awvalid = 1'b1; awaddr = 32'h10; wvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) begin
                awvalid = 1'b0; wvalid = 1'b0;
                check("A_slots_refilled", {awready, wready}, 2'b00);
            end
            check($sformatf("A_b_hold%0d", k), {bvalid, bresp}, 3'b100);
            check($sformatf("A_no_pulse%0d", k), wr_pulse, 16'h0);
            check($sformatf("A_reg4_hold%0d", k), reg_slice(4), 32'h0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("A_b_done", bvalid, 1'b0);
        check("A_reg4_not_yet", reg_slice(4), 32'h0);
        tick();
        check("A_second_bvalid", {bvalid, bresp}, 3'b100);
        check("A_second_pulse", wr_pulse, 16'h0010);
        check("A_reg4", reg_slice(4), 32'h77);
        model[4] = 32'h77;
        bready = 1'b1;
        tick();
        bready = 1'b0;

        // Read and commit to the same register on the same edge
        awvalid = 1'b1; awaddr = 32'h08; wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF;
        check("B_readies", {awready, wready}, 2'b11);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        arvalid = 1'b1; araddr = 32'h08; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        check("B_rvalid", rvalid, 1'b1);
        check("B_rdata_old", rdata, 32'h0);
        check("B_commit", {bvalid, reg_slice(2)}, {1'b1, 32'h55});
        model[2] = 32'h55;
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        axi_read(32'h08, data, resp);
        check("B_rdata_new", {resp, data}, {2'b00, 32'h55});

        // Randomized traffic against the reference model
        for (int it = 0; it < 150; it++) begin
            a = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                model_write(a, d, s, eresp, epulse);
                axi_write(a, d, s, resp, pulse, lat);
                check($sformatf("rnd%0d_bresp", it), resp, eresp);
                check($sformatf("rnd%0d_pulse", it), pulse, epulse);
                check($sformatf("rnd%0d_reg_q", it), reg_q, model_flat());
            end else begin
                if ($urandom_range(0, 3) == 0) reg_d[31:0] = $urandom;
                model_read(a, edata, eresp);
                axi_read(a, data, resp);
                check($sformatf("rnd%0d_rdata", it), data, edata);
                check($sformatf("rnd%0d_rresp", it), resp, eresp);
            end
        end

        // Reset with both B and R pending
        awvalid = 1'b1; awaddr = 32'h14; wvalid = 1'b1; wdata = 32'h99; wstrb = 4'hF; bready = 1'b0;
        arvalid = 1'b1; araddr = 32'h04; rready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();
        check("C_pending", {bvalid, rvalid}, 2'b11);
        #2 arst_n = 1'b0;
        #1;
        check("C_valids", {bvalid, rvalid}, 2'b00);
        check("C_outputs", {bresp, rresp, rdata, wr_pulse}, '0);
        check("C_readies_low", {awready, wready, arready}, 3'b000);
        check("C_reg_q", reg_q, '0);
        for (int i = 0; i < NR; i++) model[i] = '0;
        @(posedge clk);
        #3 arst_n = 1'b1;
        #1;
        check("C_readies_back", {awready, wready, arready}, 3'b111);
        bready = 1'b1; rready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("C_no_stale%0d", k), {bvalid, rvalid}, 2'b00);
        end
        bready = 1'b0; rready = 1'b0;
        axi_read(32'h14, data, resp);
        check("C_reg5_cleared", {resp, data}, {2'b00, 32'h0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slv_regs.md
# axi4_lite_slv_regs

Parametrised AXI4-Lite slave register bank that terminates the `slv` side of the AXI4-Lite interface. It exposes `P_NUM_REGS` data-width registers to surrounding logic. It supports independent AW/W acceptance, byte strobes, per-register read-only mode and SLVERR reporting. It is the DUT-side companion to the AXI4-Lite VIP and the standard register front-end for blocks in this codebase.

## Interface
- `P_DATA_WIDTH`, 32, data bus width; legal values are 32 and 64.
- `P_ADDR_WIDTH`, 32, address bus width.
- `P_NUM_REGS`, 16, number of registers; must be at least 2 and need not be a power of 2.
- `P_RO_MASK`, 0, `P_NUM_REGS`-bit mask.
  - Bit i set makes register i read-only. Reads of it return `reg_d` slice i; writes to it are rejected.
- Ports:
  - `clk` in 1: clock, rising edge.
  - `arst_n` in 1: reset, asynchronous, active-low.
  - `awvalid`/`awready` in/out 1; `awaddr` in `P_ADDR_WIDTH`; `awprot` in 3, ignored.
  - `wvalid`/`wready` in/out 1; `wdata` in `P_DATA_WIDTH`; `wstrb` in `P_DATA_WIDTH/8`.
  - `bvalid`/`bready` out/in 1; `bresp` out 2.
  - `arvalid`/`arready` in/out 1; `araddr` in `P_ADDR_WIDTH`; `arprot` in 3, ignored.
  - `rvalid`/`rready` out/in 1; `rdata` out `P_DATA_WIDTH`; `rresp` out 2.
  - `reg_q` out `P_NUM_REGS*P_DATA_WIDTH`: flat register contents, register i at `[i*P_DATA_WIDTH +: P_DATA_WIDTH]`.
  - `reg_d` in `P_NUM_REGS*P_DATA_WIDTH`: hardware values for the read-only registers; slices of writable registers are unused.
  - `wr_pulse` out `P_NUM_REGS`: one-cycle strobe per successfully written register.

## Operation
- Address decode:
  - ADDR_LSB = clog2(`P_DATA_WIDTH/8`); index = addr >> ADDR_LSB; the low ADDR_LSB bits are ignored.
  - An index of `P_NUM_REGS` or greater is out of range.
- Response codes: OKAY = 2'b00, SLVERR = 2'b10.
- Write path:
  - AW holding slot: `awready` = !aw_held; an AW handshake loads the slot with the address.
  - W holding slot: `wready` = !w_held; a W handshake loads the slot with data and strobe.
  - AW and W may arrive in either order or in the same cycle.
  - Commit condition: aw_held & w_held & !bvalid.
  - On the commit edge:
    - For a writable in-range register, each byte with its strobe bit set is updated; the other bytes keep their value.
    - `bresp` = OKAY, or SLVERR if the address is out of range or the register is read-only; a rejected write changes no register.
    - `bvalid` is set and both slots are cleared.
  - While `bvalid` is pending, the slots may refill with the next AW/W, but no commit occurs until the B handshake.
  - `bvalid` clears on `bvalid & bready`.
- Read path:
  - `arready` = !rvalid; only one read is outstanding at a time.
  - On an AR handshake edge, `rdata`/`rresp` are loaded and `rvalid` is set:
    - read-only register: `reg_d` slice, OKAY;
    - writable register: `reg_q` slice, OKAY;
    - out of range: 0, SLVERR.
  - `rdata`/`rresp` are held stable until `rvalid & rready`.
- `wr_pulse[i]` is high for exactly the one cycle following a successful commit to register i; it is not asserted for rejected writes.

## Timing
- Reset while `arst_n` is low, at any point including mid-transaction:
  - all registers = 0 and both holding slots are cleared;
  - `bvalid`, `rvalid`, `wr_pulse` = 0; `bresp`, `rresp` = 0; `rdata` = 0;
  - `awready`, `wready`, `arready` are forced to 0;
  - any in-flight transaction is dropped.
  - The ready signals go to 1 in the first cycle after deassertion.
- Write latency:
  - AW and W handshaken at edge N → commit and `bvalid` high at edge N+1; `reg_q` is updated at edge N+1.
  - If one channel arrives later, at edge M, the commit happens at M+1.
- Back-to-back writes with `bready` tied high: one write every 2 cycles.
- Read latency: AR handshake at edge N → `rvalid` high after edge N.
  - With `rready` tied high, `arready` returns at N+1, giving one read every 2 cycles.
- Read and commit to the same register on the same edge: the read returns the pre-commit value.
- The read and write paths are fully independent; neither stalls the other.
- Valid/data outputs change only on a handshake or on reset. Ready signals are combinational from internal state and `arst_n`, with no path from any input valid.

## Test plan
- Reset, then with default parameters write 0xDEADBEEF to 0x04 with strobe 0xF, then read 0x04 → `bresp` OKAY, `wr_pulse` = 16'h0002 for one cycle, `rdata` = 0xDEADBEEF, `rresp` OKAY.
- Write strobes: register 0x04 holds 0xDEADBEEF; write 0x11223344 with strobe 4'b0101 → a subsequent read returns 0xDE22BE44.
- W presented 3 cycles before AW, with `bready` low for 4 cycles after `bvalid`:
  - the commit occurs one edge after the AW handshake;
  - `bvalid` and `bresp` are held stable;
  - a second AW/W is accepted while B is pending and commits on the edge after `bready` goes high.
- Error responses:
  - write to 0x40 (index 16, out of range) → SLVERR, no change to `reg_q`, no `wr_pulse`;
  - with `P_RO_MASK` = 16'h0001 and `reg_d[31:0]` = 0xCAFE0001, a write to 0x00 → SLVERR, and a read of 0x00 returns 0xCAFE0001 OKAY;
  - read of 0x40 → `rdata` 0, SLVERR.
- Same-edge read and commit to 0x08 (old value 0x0, new 0x55) → `rdata` = 0x0; the next read returns 0x55.
- Assert `arst_n` low while `bvalid` and `rvalid` are pending:
  - all outputs return to 0 immediately and registers clear;
  - after release, the ready signals are 1 within one cycle and no stale B or R response appears.
